regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (RegWrite / WriteReg / WriteData) between NUM_REQ writeback requesters: ALU, load/store unit and mul/div unit.
- Uses a round-robin valid/ready handshake and a one-cycle registered output stage.
- Suppresses writes to x0.
- Publishes a pending-destination mask that decode uses for RAW stall detection.
- Sits between the execute/memory stages and register_file.

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/regfile_wb_arbiter_if.sv | 36 +++
 rtl/regfile_wb_arbiter_rr.sv | 37 +++
 rtl/regfile_wb_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared core-wide definitions: datapath widths, register-file geometry,
// writeback requester indices and the writeback request record.
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // Writeback requester indices (slice position on the arbiter inputs).
    localparam int WB_ALU     = 0;
    localparam int WB_LSU     = 1;
    localparam int WB_MULDIV  = 2;
    localparam int NUM_WB_REQ = 3;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // One-hot decode of a destination register; x0 never appears in the result
    // because a write to x0 has no architectural effect.
    function automatic logic [NUM_REGS-1:0] decodeRd(input logic [REG_ADDR_W-1:0] rd);
        decodeRd = '0;
        if (rd != '0) begin
            decodeRd[rd] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Writeback request bus between the execute/memory units and the register
// file write-port arbiter. Slice i of each vector belongs to requester i.
//   req_valid  requester -> arbiter  requester i holds a completed result
//   req_rd     requester -> arbiter  destination register, REG_ADDR_W per slice
//   req_data   requester -> arbiter  result data, XLEN per slice
//   req_ready  arbiter -> requester  one-hot grant
// modport master: requester side; modport slave: arbiter side.
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*REG_ADDR_W-1:0] req_rd;
    logic [NUM_REQ*XLEN-1:0]       req_data;
    logic [NUM_REQ-1:0]            req_ready;

    modport master (
        output req_valid,
        output req_rd,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_rd,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Scans req starting at index ptr,
// wrapping modulo N, and grants the first asserted request. Reusable for any
// N-way shared resource.
//   req  in   N      request vector
//   ptr  in   PTR_W  index with highest priority this cycle
//   gnt  out  N      one-hot grant, all-zero when no request is set
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic found;
    int   idx;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the loop leaves one unassigned and infers a latch.
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single register-file write port among NUM_REQ writeback units
// (ALU, LSU, MULDIV) with round-robin valid/ready arbitration and a one-cycle
// registered output stage. Writes to x0 are consumed but never enabled.
// Also publishes the pending-destination mask used by decode for RAW stalls.
//   clk           in   1           rising-edge clock
//   rst           in   1           synchronous, active-high reset
//   wbReq         slave modport    req_valid / req_rd / req_data / req_ready
//   RegWrite      out  1           register file write enable
//   WriteReg      out  REG_ADDR_W  register file write index
//   WriteData     out  XLEN        register file write data
//   wb_src        out  IDX_W       requester whose write is on the port
//   pending_mask  out  32          register r has a write requested or in flight
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int NUM_REQ    = riscv_pkg::NUM_WB_REQ,
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W,
    parameter int IDX_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   wbReq,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic [XLEN-1:0]       WriteData,
    output logic [IDX_W-1:0]      wb_src,
    output logic [31:0]           pending_mask
);

    import riscv_pkg::*;

    logic [IDX_W-1:0]      rrPtr;
    logic [IDX_W-1:0]      rrPtrNext;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    accept;
    logic                  anyAccept;
    logic [IDX_W-1:0]      grantIdx;
    logic [REG_ADDR_W-1:0] grantRd;
    logic [XLEN-1:0]       grantData;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (IDX_W)
    ) u_rrArbiter (
        .req (wbReq.req_valid),
        .ptr (rrPtr),
        .gnt (grant)
    );

    // Grants are withheld during reset so nothing is consumed that the
    // reset is about to discard.
    assign wbReq.req_ready = rst ? '0 : grant;
    assign accept          = wbReq.req_ready & wbReq.req_valid;
    assign anyAccept       = |accept;

    // Mux the accepted requester's payload onto the output-stage inputs.
    always_comb begin
        grantIdx  = '0;
        grantRd   = '0;
        grantData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                grantIdx  = IDX_W'(i);
                grantRd   = wbReq.req_rd[i*REG_ADDR_W +: REG_ADDR_W];
                grantData = wbReq.req_data[i*XLEN +: XLEN];
            end
        end
    end

    // With NUM_REQ = 1 this always evaluates to 0, pinning the pointer.
    assign rrPtrNext = IDX_W'((int'(grantIdx) + 1) % NUM_REQ);

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            wb_src    <= '0;
            rrPtr     <= '0;
        end else begin
            RegWrite <= anyAccept && (grantRd != '0);
            if (anyAccept) begin
                WriteReg  <= grantRd;
                WriteData <= grantData;
                wb_src    <= grantIdx;
                rrPtr     <= rrPtrNext;
            end
        end
    end

    // Requested destinations plus the write currently on the port. The
    // in-flight term is masked during reset since that write is being dropped.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wbReq.req_valid[i]) begin
                pending_mask = pending_mask | decodeRd(wbReq.req_rd[i*REG_ADDR_W +: REG_ADDR_W]);
            end
        end
        if (RegWrite && !rst) begin
            pending_mask = pending_mask | decodeRd(WriteReg);
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed stimulus; expected register-file writes are queued by the driver
// and consumed by a monitor whenever RegWrite is observed.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    import riscv_pkg::*;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        logic [1:0]  src;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [63:0] WriteData;
    logic [1:0]  wb_src;
    logic [31:0] pending_mask;

    int   total = 0;
    int   bad   = 0;
    exp_t expQ[$];
    exp_t monE;

    regfile_wb_arbiter_if #(.NUM_REQ(3), .XLEN(64), .REG_ADDR_W(5)) wbIf ();

    regfile_wb_arbiter #(
        .NUM_REQ    (3),
        .XLEN       (64),
        .REG_ADDR_W (5),
        .IDX_W      (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wbReq        (wbIf),
        .RegWrite     (RegWrite),
        .WriteReg     (WriteReg),
        .WriteData    (WriteData),
        .wb_src       (wb_src),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic setReq(input int i, input wb_req_t r);
        wbIf.req_valid[i]       = r.valid;
        wbIf.req_rd[i*5 +: 5]   = r.rd;
        wbIf.req_data[i*64 +: 64] = r.data;
    endtask

    task automatic clearReq(input int i);
        setReq(i, '{valid: 1'b0, rd: 5'd0, data: 64'd0});
    endtask

    task automatic expectWrite(input logic [4:0] rd, input logic [63:0] data, input logic [1:0] src);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        e.src  = src;
        expQ.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (RegWrite === 1'b1) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%0h src=%0d, expected no write",
                         WriteReg, WriteData, wb_src);
            end else begin
                monE = expQ.pop_front();
                check("wr_reg",  64'(WriteReg),  64'(monE.rd));
                check("wr_data", WriteData,      monE.data);
                check("wr_src",  64'(wb_src),    64'(monE.src));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] fairData[3];
        fairData[0] = 64'h100;
        fairData[1] = 64'h200;
        fairData[2] = 64'h300;

        // Reset with all three requesters valid.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setReq(i, '{valid: 1'b1, rd: 5'(i + 1), data: fairData[i]});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready",     64'(wbIf.req_ready), 64'b000);
        check("rst_regwrite",  64'(RegWrite),       64'd0);
        check("rst_writereg",  64'(WriteReg),       64'd0);
        check("rst_writedata", WriteData,           64'd0);
        check("rst_wb_src",    64'(wb_src),         64'd0);
        check("rst_pending",   64'(pending_mask),   64'h0000_000E);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fairness: 0,1,2,0,1,2 with back-to-back writes.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("fair_ready_%0d", k), 64'(wbIf.req_ready), 64'(3'b001 << (k % 3)));
            check($sformatf("fair_regwrite_%0d", k), 64'(RegWrite), (k > 0) ? 64'd1 : 64'd0);
            if (k == 3) begin
                check("fair_pending", 64'(pending_mask), 64'h0000_000E);
            end
            expectWrite(5'(k % 3 + 1), fairData[k % 3], 2'(k % 3));
            nextCycle();
        end
        for (int i = 0; i < 3; i++) clearReq(i);
        @(negedge clk);
        check("fair_tail_regwrite", 64'(RegWrite),       64'd1);
        check("fair_tail_ready",    64'(wbIf.req_ready), 64'b000);
        nextCycle();
        @(negedge clk);
        check("fair_idle_regwrite", 64'(RegWrite), 64'd0);

        // Single ALU request: one-cycle latency, single-cycle pulse.
        nextCycle();
        setReq(WB_ALU, '{valid: 1'b1, rd: 5'd5, data: 64'h2A});
        @(negedge clk);
        check("single_ready", 64'(wbIf.req_ready), 64'b001);
        expectWrite(5'd5, 64'h2A, 2'd0);
        nextCycle();
        clearReq(WB_ALU);
        @(negedge clk);
        check("single_regwrite", 64'(RegWrite),     64'd1);
        check("single_inflight", 64'(pending_mask), 64'h0000_0020);
        nextCycle();
        @(negedge clk);
        check("single_done_regwrite", 64'(RegWrite),     64'd0);
        check("single_done_pending",  64'(pending_mask), 64'd0);

        // x0 request from LSU: consumed, never written, never pending.
        nextCycle();
        setReq(WB_LSU, '{valid: 1'b1, rd: 5'd0, data: 64'hFF});
        @(negedge clk);
        check("x0_ready",   64'(wbIf.req_ready), 64'b010);
        check("x0_pending", 64'(pending_mask),   64'd0);
        nextCycle();
        clearReq(WB_LSU);
        @(negedge clk);
        check("x0_regwrite",  64'(RegWrite),     64'd0);
        check("x0_pending2",  64'(pending_mask), 64'd0);
        check("x0_wb_src",    64'(wb_src),       64'd1);
        check("x0_writedata", WriteData,         64'hFF);

        // MULDIV request brings the pointer back to 0.
        nextCycle();
        setReq(WB_MULDIV, '{valid: 1'b1, rd: 5'd10, data: 64'h55});
        @(negedge clk);
        check("mul_ready", 64'(wbIf.req_ready), 64'b100);
        expectWrite(5'd10, 64'h55, 2'd2);
        nextCycle();
        clearReq(WB_MULDIV);

        // Same-rd collision: ALU then MULDIV, later write wins.
        setReq(WB_ALU,    '{valid: 1'b1, rd: 5'd7, data: 64'd1});
        setReq(WB_MULDIV, '{valid: 1'b1, rd: 5'd7, data: 64'd2});
        @(negedge clk);
        check("coll_ready_n",  64'(wbIf.req_ready), 64'b001);
        check("coll_pend7_n",  64'(pending_mask[7]), 64'd1);
        expectWrite(5'd7, 64'd1, 2'd0);
        nextCycle();
        clearReq(WB_ALU);
        @(negedge clk);
        check("coll_ready_n1", 64'(wbIf.req_ready), 64'b100);
        check("coll_pend7_n1", 64'(pending_mask[7]), 64'd1);
        expectWrite(5'd7, 64'd2, 2'd2);
        nextCycle();
        clearReq(WB_MULDIV);
        @(negedge clk);
        check("coll_pend7_n2", 64'(pending_mask[7]), 64'd1);
        nextCycle();
        @(negedge clk);
        check("coll_pend7_n3",    64'(pending_mask[7]), 64'd0);
        check("coll_regwrite_n3", 64'(RegWrite),        64'd0);

        // Reset mid-flight: LSU grant is dropped, then re-granted from ptr 0.
        nextCycle();
        setReq(WB_LSU, '{valid: 1'b1, rd: 5'd9, data: 64'h99});
        @(negedge clk);
        check("mid_ready", 64'(wbIf.req_ready), 64'b010);
        rst = 1'b1;
        nextCycle();
        @(negedge clk);
        check("mid_rst_regwrite", 64'(RegWrite),       64'd0);
        check("mid_rst_ready",    64'(wbIf.req_ready), 64'b000);
        check("mid_rst_pending",  64'(pending_mask),   64'h0000_0200);
        check("mid_rst_wb_src",   64'(wb_src),         64'd0);
        nextCycle();
        rst = 1'b0;
        setReq(WB_MULDIV, '{valid: 1'b1, rd: 5'd11, data: 64'h77});
        @(negedge clk);
        check("post_rst_ready_lsu", 64'(wbIf.req_ready), 64'b010);
        expectWrite(5'd9, 64'h99, 2'd1);
        nextCycle();
        clearReq(WB_LSU);
        @(negedge clk);
        check("post_rst_ready_mul", 64'(wbIf.req_ready), 64'b100);
        expectWrite(5'd11, 64'h77, 2'd2);
        nextCycle();
        clearReq(WB_MULDIV);
        @(negedge clk);
        nextCycle();
        @(negedge clk);
        check("queue_drained", 64'(expQ.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
